// File: rtl/card_dealer.sv
// Card dealer: deals unique cards 0..51 from a 52-bit dealt mask, seeded by an external RNG.
// Latency: card_valid three cycles after deal_req when the first probed slot is free, +1 per skipped slot.
// Backpressure: deal_req is ignored while busy; shuffle aborts any deal. Option macro: DEALER_AUTO_SHUFFLE_EN.
module card_dealer #(
  parameter int unsigned ACE_POINTS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       rand_request,
  input  logic [5:0] rand_value,
  output logic       card_valid,
  output logic [5:0] card_id,
  output logic [3:0] card_rank,
  output logic [3:0] card_points,
  output logic       busy,
  output logic       empty_err,
  output logic [5:0] cards_left
);

  typedef enum logic [1:0] {IDLE, REQUEST, SEARCH, DELIVER} state_t;

  state_t      state_q;
  logic [51:0] mask_q;
  logic [5:0]  ptr_q;
  logic [5:0]  cards_left_q;
  logic [5:0]  card_id_q;
  logic [3:0]  card_rank_q;
  logic [3:0]  card_points_q;
  logic        card_valid_q;
  logic        rand_request_q;
  logic        empty_err_q;

  logic [5:0]  ptr_load_d;
  logic [5:0]  ptr_next_d;
  logic [5:0]  rank_idx_d;
  logic [3:0]  rank_d;
  logic [3:0]  points_d;

  // Fold the RNG value into 0..51, advance the scan pointer with wrap, and decode rank/points of the probed slot.
  always_comb begin
    ptr_load_d = (rand_value < 6'd52) ? rand_value : rand_value - 6'd52;
    ptr_next_d = (ptr_q == 6'd51) ? 6'd0 : ptr_q + 6'd1;
    rank_idx_d = ptr_q;
    if (ptr_q >= 6'd39)      rank_idx_d = ptr_q - 6'd39;
    else if (ptr_q >= 6'd26) rank_idx_d = ptr_q - 6'd26;
    else if (ptr_q >= 6'd13) rank_idx_d = ptr_q - 6'd13;
    rank_d = 4'(rank_idx_d + 6'd1);
    if (rank_d == 4'd1)      points_d = 4'(ACE_POINTS);
    else if (rank_d > 4'd10) points_d = 4'd10;
    else                     points_d = rank_d;
  end

  // Deal FSM with deck state and registered outputs; reset beats shuffle, shuffle beats everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      ptr_q          <= '0;
      cards_left_q   <= 6'd52;
      card_id_q      <= '0;
      card_rank_q    <= '0;
      card_points_q  <= '0;
      card_valid_q   <= 1'b0;
      rand_request_q <= 1'b0;
      empty_err_q    <= 1'b0;
    end else begin
      card_valid_q   <= 1'b0;
      rand_request_q <= 1'b0;
      empty_err_q    <= 1'b0;
      if (shuffle) begin
        mask_q       <= '0;
        cards_left_q <= 6'd52;
        state_q      <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (deal_req) begin
              if (cards_left_q != 6'd0) begin
                state_q        <= REQUEST;
                rand_request_q <= 1'b1;
              end else begin
`ifdef DEALER_AUTO_SHUFFLE_EN
                // Empty deck refills itself and the deal proceeds with normal latency.
                mask_q         <= '0;
                cards_left_q   <= 6'd52;
                state_q        <= REQUEST;
                rand_request_q <= 1'b1;
`else
                empty_err_q    <= 1'b1;
`endif
              end
            end
          end
          REQUEST: begin
            ptr_q   <= ptr_load_d;
            state_q <= SEARCH;
          end
          SEARCH: begin
            // Entry guarantees at least one free slot, so this scan always terminates within 52 probes.
            if (!mask_q[ptr_q]) begin
              mask_q[ptr_q] <= 1'b1;
              card_id_q     <= ptr_q;
              card_rank_q   <= rank_d;
              card_points_q <= points_d;
              cards_left_q  <= cards_left_q - 6'd1;
              card_valid_q  <= 1'b1;
              state_q       <= DELIVER;
            end else begin
              ptr_q <= ptr_next_d;
            end
          end
          DELIVER: begin
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rand_request = rand_request_q;
  assign card_valid   = card_valid_q;
  assign card_id      = card_id_q;
  assign card_rank    = card_rank_q;
  assign card_points  = card_points_q;
  assign busy         = (state_q != IDLE);
  assign empty_err    = empty_err_q;
  assign cards_left   = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: main instance uses ACE_POINTS=11, a second default instance shares all inputs.
`timescale 1ns/1ps
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       deal_req = 1'b0;
  logic       shuffle = 1'b0;
  logic [5:0] rand_value = 6'd0;

  logic       rand_request, card_valid, busy, empty_err;
  logic [5:0] card_id, cards_left;
  logic [3:0] card_rank, card_points;

  logic       rand_request1, card_valid1, busy1, empty_err1;
  logic [5:0] card_id1, cards_left1;
  logic [3:0] card_rank1, card_points1;

  int checks = 0;
  int errors = 0;

  card_dealer #(.ACE_POINTS(11)) u_dut (
    .clk(clk), .reset(reset), .deal_req(deal_req), .shuffle(shuffle),
    .rand_request(rand_request), .rand_value(rand_value),
    .card_valid(card_valid), .card_id(card_id), .card_rank(card_rank),
    .card_points(card_points), .busy(busy), .empty_err(empty_err),
    .cards_left(cards_left)
  );

  card_dealer u_dut1 (
    .clk(clk), .reset(reset), .deal_req(deal_req), .shuffle(shuffle),
    .rand_request(rand_request1), .rand_value(rand_value),
    .card_valid(card_valid1), .card_id(card_id1), .card_rank(card_rank1),
    .card_points(card_points1), .busy(busy1), .empty_err(empty_err1),
    .cards_left(cards_left1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
  endtask

  // One deal: lat = edges after the sampling edge until card_valid (2 means cycle N+3), -1 on timeout.
  task automatic do_deal(input logic [5:0] rv, output int lat, output int rq_cnt);
    rand_value = rv;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    rq_cnt = rand_request ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (rand_request) rq_cnt++;
      if (card_valid) begin
        lat = k;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (card_valid !== 1'b0) begin errors++; $display("FAIL reset_card_valid got %0b exp 0", card_valid); end
    checks++; if (rand_request !== 1'b0) begin errors++; $display("FAIL reset_rand_request got %0b exp 0", rand_request); end
    checks++; if (empty_err !== 1'b0) begin errors++; $display("FAIL reset_empty_err got %0b exp 0", empty_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (card_id !== 6'd0) begin errors++; $display("FAIL reset_card_id got %0d exp 0", card_id); end
    checks++; if (card_rank !== 4'd0) begin errors++; $display("FAIL reset_card_rank got %0d exp 0", card_rank); end
    checks++; if (card_points !== 4'd0) begin errors++; $display("FAIL reset_card_points got %0d exp 0", card_points); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL reset_cards_left got %0d exp 52", cards_left); end
    checks++;
    if ({card_valid1, rand_request1, empty_err1, busy1} !== 4'b0000 || card_id1 !== 6'd0 ||
        card_rank1 !== 4'd0 || card_points1 !== 4'd0 || cards_left1 !== 6'd52) begin
      errors++;
      $display("FAIL reset_default_inst got v%0b r%0b e%0b b%0b id%0d rk%0d pt%0d left%0d exp zeros and left 52",
               card_valid1, rand_request1, empty_err1, busy1, card_id1, card_rank1, card_points1, cards_left1);
    end
  endtask

  task automatic test_basic_deal();
    int lat, rq;
    do_deal(6'd5, lat, rq);
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", lat); end
    checks++; if (rq != 1) begin errors++; $display("FAIL basic_rand_request_cycles got %0d exp 1", rq); end
    checks++; if (card_id !== 6'd5) begin errors++; $display("FAIL basic_card_id got %0d exp 5", card_id); end
    checks++; if (card_rank !== 4'd6) begin errors++; $display("FAIL basic_card_rank got %0d exp 6", card_rank); end
    checks++; if (card_points !== 4'd6) begin errors++; $display("FAIL basic_card_points got %0d exp 6", card_points); end
    checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL basic_cards_left got %0d exp 51", cards_left); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b exp 0", busy); end
  endtask

  task automatic test_skip_dealt();
    int lat, rq;
    do_deal(6'd57, lat, rq);
    checks++; if (lat != 3) begin errors++; $display("FAIL skip_latency got %0d exp 3", lat); end
    checks++; if (card_id !== 6'd6) begin errors++; $display("FAIL skip_card_id got %0d exp 6", card_id); end
    checks++; if (cards_left !== 6'd50) begin errors++; $display("FAIL skip_cards_left got %0d exp 50", cards_left); end
  endtask

  task automatic test_busy_ignore();
    int vcnt = 0;
    int rqcnt = 0;
    rand_value = 6'd3;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    tick();
    deal_req = 1'b1;
    tick();
    if (card_valid) vcnt++;
    deal_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (card_valid) vcnt++;
      if (rand_request) rqcnt++;
    end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL busy_ignore_valid_pulses got %0d exp 1", vcnt); end
    checks++; if (rqcnt != 0) begin errors++; $display("FAIL busy_ignore_extra_requests got %0d exp 0", rqcnt); end
    checks++; if (card_id !== 6'd3) begin errors++; $display("FAIL busy_ignore_card_id got %0d exp 3", card_id); end
    checks++; if (cards_left !== 6'd49) begin errors++; $display("FAIL busy_ignore_cards_left got %0d exp 49", cards_left); end
  endtask

  task automatic test_full_deck();
    int lat, rq;
    do_shuffle();
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL deck_shuffle_left got %0d exp 52", cards_left); end
    for (int i = 0; i < 52; i++) begin
      do_deal(6'd0, lat, rq);
      checks++;
      if (card_id !== 6'(i) || lat != i + 2) begin
        errors++;
        $display("FAIL deck_seq deal %0d got id %0d lat %0d exp id %0d lat %0d", i, card_id, lat, i, i + 2);
      end
    end
    checks++; if (cards_left !== 6'd0) begin errors++; $display("FAIL deck_cards_left got %0d exp 0", cards_left); end
`ifdef DEALER_AUTO_SHUFFLE_EN
    do_deal(6'd0, lat, rq);
    checks++; if (lat != 2) begin errors++; $display("FAIL auto_latency got %0d exp 2", lat); end
    checks++; if (card_id !== 6'd0) begin errors++; $display("FAIL auto_card_id got %0d exp 0", card_id); end
    checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL auto_cards_left got %0d exp 51", cards_left); end
    checks++; if (empty_err !== 1'b0) begin errors++; $display("FAIL auto_empty_err got %0b exp 0", empty_err); end
`else
    rand_value = 6'd0;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    checks++; if (empty_err !== 1'b1) begin errors++; $display("FAIL empty_err_pulse got %0b exp 1", empty_err); end
    checks++; if (rand_request !== 1'b0) begin errors++; $display("FAIL empty_rand_request got %0b exp 0", rand_request); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got %0b exp 0", busy); end
    tick();
    checks++; if (empty_err !== 1'b0) begin errors++; $display("FAIL empty_err_width got %0b exp 0", empty_err); end
    checks++; if (rand_request !== 1'b0) begin errors++; $display("FAIL empty_rand_request_late got %0b exp 0", rand_request); end
    checks++; if (cards_left !== 6'd0) begin errors++; $display("FAIL empty_cards_left got %0d exp 0", cards_left); end
`endif
  endtask

  task automatic test_ace_points();
    int lat, rq;
    do_shuffle();
    do_deal(6'd13, lat, rq);
    checks++; if (card_id !== 6'd13 || card_rank !== 4'd1) begin errors++; $display("FAIL ace_id_rank got %0d/%0d exp 13/1", card_id, card_rank); end
    checks++; if (card_points !== 4'd11) begin errors++; $display("FAIL ace_points11 got %0d exp 11", card_points); end
    checks++; if (card_points1 !== 4'd1 || card_rank1 !== 4'd1) begin errors++; $display("FAIL ace_points1 got %0d rank %0d exp 1 rank 1", card_points1, card_rank1); end
    do_deal(6'd25, lat, rq);
    checks++; if (card_id !== 6'd25 || card_rank !== 4'd13) begin errors++; $display("FAIL king_id_rank got %0d/%0d exp 25/13", card_id, card_rank); end
    checks++; if (card_points !== 4'd10 || card_points1 !== 4'd10) begin errors++; $display("FAIL king_points got %0d/%0d exp 10/10", card_points, card_points1); end
    do_deal(6'd9, lat, rq);
    checks++; if (card_rank !== 4'd10 || card_points !== 4'd10) begin errors++; $display("FAIL ten_rank_points got %0d/%0d exp 10/10", card_rank, card_points); end
    do_deal(6'd1, lat, rq);
    checks++; if (card_rank !== 4'd2 || card_points !== 4'd2) begin errors++; $display("FAIL two_rank_points got %0d/%0d exp 2/2", card_rank, card_points); end
  endtask

  task automatic test_shuffle_mid_search();
    int lat, rq;
    int vcnt = 0;
    do_shuffle();
    for (int i = 0; i < 40; i++) do_deal(6'd0, lat, rq);
    checks++; if (cards_left !== 6'd12) begin errors++; $display("FAIL mid_setup_cards_left got %0d exp 12", cards_left); end
    rand_value = 6'd0;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (card_valid) vcnt++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_in_search got %0b exp 1", busy); end
    do_shuffle();
    if (card_valid) vcnt++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after_shuffle got %0b exp 0", busy); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL mid_cards_left got %0d exp 52", cards_left); end
    tick();
    if (card_valid) vcnt++;
    checks++; if (vcnt != 0) begin errors++; $display("FAIL mid_no_card_valid got %0d pulses exp 0", vcnt); end
    do_deal(6'd0, lat, rq);
    checks++; if (card_id !== 6'd0 || lat != 2) begin errors++; $display("FAIL mid_mask_cleared got id %0d lat %0d exp id 0 lat 2", card_id, lat); end
  endtask

  task automatic test_shuffle_deal_and_reset();
    int lat, rq;
    do_deal(6'd20, lat, rq);
    checks++; if (card_id !== 6'd20 || cards_left !== 6'd50) begin errors++; $display("FAIL together_setup got id %0d left %0d exp 20/50", card_id, cards_left); end
    rand_value = 6'd7;
    shuffle = 1'b1;
    deal_req = 1'b1;
    tick();
    shuffle = 1'b0;
    deal_req = 1'b0;
    checks++; if (rand_request !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL together_no_request got rq %0b busy %0b exp 0/0", rand_request, busy); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL together_cards_left got %0d exp 52", cards_left); end
    tick();
    checks++; if (rand_request !== 1'b0) begin errors++; $display("FAIL together_no_request_late got %0b exp 0", rand_request); end
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    checks++; if (rand_request !== 1'b1) begin errors++; $display("FAIL reset_req_in_request got %0b exp 1", rand_request); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({card_valid, rand_request, empty_err, busy} !== 4'b0000 || card_id !== 6'd0 ||
        card_rank !== 4'd0 || card_points !== 4'd0 || cards_left !== 6'd52) begin
      errors++;
      $display("FAIL reset_mid_deal got v%0b r%0b e%0b b%0b id%0d rk%0d pt%0d left%0d exp zeros and left 52",
               card_valid, rand_request, empty_err, busy, card_id, card_rank, card_points, cards_left);
    end
    tick();
    checks++; if (card_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_deal_late got v%0b b%0b exp 0/0", card_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_basic_deal();
    test_skip_dealt();
    test_busy_ignore();
    test_full_deck();
    test_ace_points();
    test_shuffle_mid_search();
    test_shuffle_deal_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
